// File: rtl/shift_chain_sequencer_pkg.sv
// shift_chain_pkg: shared types and helpers for the shift_chain_sequencer block.
//   chain_state_e : controller state (IDLE, RUN, HOLD, DRAIN)
//   occ_width()   : bit width needed to count 0..depth valid stages
package shift_chain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } chain_state_e;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/shift_chain_sequencer_if.sv
// shift_chain_sequencer_if: producer/consumer handshake plus control/status bundle.
//   in_valid/in_ready/in_data    : producer side of the chain
//   out_valid/out_ready/out_data : consumer side of the chain
//   hold_req, drain_req          : sequencing controls
//   drain_done, busy, occupancy  : status
// Modports: master = environment driving the chain, slave = the chain itself.
interface shift_chain_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  import shift_chain_pkg::*;

  localparam int OCC_W = occ_width(DEPTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             hold_req;
  logic             drain_req;
  logic             drain_done;
  logic             busy;
  logic [OCC_W-1:0] occupancy;

  modport master (
    output in_valid, in_data, out_ready, hold_req, drain_req,
    input  in_ready, out_valid, out_data, drain_done, busy, occupancy
  );

  modport slave (
    input  in_valid, in_data, out_ready, hold_req, drain_req,
    output in_ready, out_valid, out_data, drain_done, busy, occupancy
  );

endinterface

// File: rtl/shift_chain_sequencer_stage.sv
// shift_chain_stage: one storage stage of the chain (data register + valid bit).
//   clk, rst : clock, asynchronous active-high reset
//   load     : capture d and mark the stage valid (wins over clear)
//   clear    : data has left and nothing replaces it; drop the valid bit
//   d / q    : data in / stored data
//   vld      : stage holds a live item
module shift_chain_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             vld
);

  // Stage storage: load has priority, data is kept untouched on clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= {WIDTH{1'b0}};
      vld <= 1'b0;
    end else if (load) begin
      q   <= d;
      vld <= 1'b1;
    end else if (clear) begin
      q   <= q;
      vld <= 1'b0;
    end else begin
      q   <= q;
      vld <= vld;
    end
  end

endmodule

// File: rtl/shift_chain_sequencer.sv
// shift_chain_sequencer: elastic, deterministic-latency delay line of DEPTH stages
// with bubble collapsing, hold (freeze) and drain (empty-out) sequencing.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : shift_chain_sequencer_if.slave (handshakes, controls, status)
// Build option: define SHIFT_CHAIN_OCC_EN to build the registered occupancy
// counter; otherwise occupancy reads 0 and no counter exists.
module shift_chain_sequencer
  import shift_chain_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic                    clk,
  input logic                    rst,
  shift_chain_sequencer_if.slave bus
);

  chain_state_e     state_r, state_next_s;
  logic             drain_pending_r, drain_pending_next_s;
  logic             drain_done_r, drain_done_next_s;
  logic [DEPTH-1:0] vld_s, adv_s, load_s, clear_s, vld_next_s;
  logic [WIDTH-1:0] data_s [DEPTH];
  logic             accept_s, emit_s, in_ready_s, out_valid_s;

  // Advance chain: an item moves when the slot ahead is empty or vacating; hold freezes all.
  always_comb begin
    adv_s = {DEPTH{1'b0}};
    adv_s[DEPTH-1] = vld_s[DEPTH-1] & bus.out_ready & ~bus.hold_req;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      adv_s[i] = vld_s[i] & (~vld_s[i+1] | adv_s[i+1]) & ~bus.hold_req;
    end
  end

  // Stage load/clear controls and the valid pattern after this edge.
  always_comb begin
    accept_s  = bus.in_valid & in_ready_s;
    emit_s    = adv_s[DEPTH-1];
    load_s    = {DEPTH{1'b0}};
    load_s[0] = accept_s;
    for (int i = 1; i < DEPTH; i++) begin
      load_s[i] = adv_s[i-1];
    end
    clear_s    = adv_s & ~load_s;
    vld_next_s = load_s | (vld_s & ~adv_s);
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [WIDTH-1:0] d_s;
    if (g == 0) begin : g_head
      assign d_s = bus.in_data;
    end else begin : g_body
      assign d_s = data_s[g-1];
    end
    shift_chain_stage #(.WIDTH(WIDTH)) u_stage (
      .clk   (clk),
      .rst   (rst),
      .load  (load_s[g]),
      .clear (clear_s[g]),
      .d     (d_s),
      .q     (data_s[g]),
      .vld   (vld_s[g])
    );
  end

  // Controller state register with the pending-drain latch and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= IDLE;
      drain_pending_r <= 1'b0;
      drain_done_r    <= 1'b0;
    end else begin
      state_r         <= state_next_s;
      drain_pending_r <= drain_pending_next_s;
      drain_done_r    <= drain_done_next_s;
    end
  end

  // Next-state logic: hold always wins; a drain seen during hold is parked in drain_pending.
  always_comb begin
    state_next_s         = state_r;
    drain_pending_next_s = drain_pending_r;
    drain_done_next_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.hold_req) begin
          drain_pending_next_s = drain_pending_r | bus.drain_req;
        end else if (bus.drain_req | drain_pending_r) begin
          // Empty chain completes at once unless an item slipped in on this edge.
          drain_pending_next_s = 1'b0;
          if (accept_s) begin
            state_next_s = DRAIN;
          end else begin
            drain_done_next_s = 1'b1;
          end
        end else if (accept_s) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (bus.hold_req) begin
          drain_pending_next_s = drain_pending_r | bus.drain_req;
          state_next_s         = HOLD;
        end else if (bus.drain_req | drain_pending_r) begin
          drain_pending_next_s = 1'b0;
          state_next_s         = DRAIN;
        end else begin
          state_next_s = RUN;
        end
      end
      HOLD: begin
        if (bus.hold_req) begin
          drain_pending_next_s = drain_pending_r | bus.drain_req;
        end else if (bus.drain_req | drain_pending_r) begin
          drain_pending_next_s = 1'b0;
          state_next_s         = DRAIN;
        end else begin
          state_next_s = RUN;
        end
      end
      DRAIN: begin
        drain_pending_next_s = 1'b0;
        if (bus.hold_req) begin
          state_next_s = DRAIN;
        end else if (vld_next_s == {DEPTH{1'b0}}) begin
          state_next_s      = IDLE;
          drain_done_next_s = 1'b1;
        end else begin
          state_next_s = DRAIN;
        end
      end
      default: begin
        state_next_s         = IDLE;
        drain_pending_next_s = 1'b0;
      end
    endcase
  end

  // Handshake outputs: accept only in IDLE/RUN, never while frozen or with a drain parked.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      IDLE, RUN: begin
        in_ready_s = (~vld_s[0] | adv_s[0]) & ~bus.hold_req & ~drain_pending_r & ~rst;
      end
      default: begin
        in_ready_s = 1'b0;
      end
    endcase
    out_valid_s = vld_s[DEPTH-1] & ~bus.hold_req;
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_s;
  assign bus.out_data   = data_s[DEPTH-1];
  assign bus.drain_done = drain_done_r;
  assign bus.busy       = (state_r != IDLE);

`ifdef SHIFT_CHAIN_OCC_EN
  localparam int OCC_W = occ_width(DEPTH);
  logic [OCC_W-1:0] occ_r;

  // Occupancy tracks the valid count: +1 on accept, -1 on emit, unchanged when both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_r <= {OCC_W{1'b0}};
    end else if (accept_s & ~emit_s) begin
      occ_r <= occ_r + OCC_W'(1);
    end else if (~accept_s & emit_s) begin
      occ_r <= occ_r - OCC_W'(1);
    end else begin
      occ_r <= occ_r;
    end
  end

  assign bus.occupancy = occ_r;
`else
  assign bus.occupancy = '0;
`endif

endmodule

// File: tb/tb_shift_chain_sequencer.sv
// tb_shift_chain_sequencer: directed scenarios plus randomized traffic, checked every
// cycle against an item-queue model of the chain.
module tb_shift_chain_sequencer;
  import shift_chain_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
`ifdef SHIFT_CHAIN_OCC_EN
  localparam bit OCC_EN = 1'b1;
`else
  localparam bit OCC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  shift_chain_sequencer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  shift_chain_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: ordered list of items with slot positions
  typedef struct {
    logic [7:0] d;
    int         pos;
  } item_t;

  typedef enum int {M_IDLE, M_RUN, M_HOLD, M_DRAIN} mode_t;

  item_t mq[$];
  mode_t m_mode    = M_IDLE;
  bit    m_pending = 1'b0;
  bit    m_done    = 1'b0;
  bit    mv_leave;
  int    mv_np [DEPTH];

  // Items slide one slot toward the output whenever the slot ahead is free after this edge.
  function automatic void plan_moves(input bit hold, input bit ordy);
    int limit;
    mv_leave = 1'b0;
    limit    = DEPTH;
    for (int k = 0; k < mq.size(); k++) begin
      if (hold) begin
        mv_np[k] = mq[k].pos;
      end else if (k == 0 && mq[k].pos == DEPTH - 1) begin
        mv_leave = ordy;
        mv_np[k] = mq[k].pos;
      end else begin
        mv_np[k] = (mq[k].pos + 1 < limit) ? mq[k].pos + 1 : mq[k].pos;
      end
      limit = (k == 0 && mv_leave) ? DEPTH : mv_np[k];
    end
  endfunction

  function automatic bit exp_in_ready();
    bit slot0_free;
    plan_moves(bus.hold_req, bus.out_ready);
    slot0_free = (mq.size() == 0) || (mv_np[mq.size()-1] > 0);
    return !rst && (m_mode == M_IDLE || m_mode == M_RUN) && !bus.hold_req
           && !m_pending && slot0_free;
  endfunction

  function automatic bit exp_out_valid();
    return !bus.hold_req && mq.size() > 0 && mq[0].pos == DEPTH - 1;
  endfunction

  // Model update on each active edge (and immediately on reset assertion).
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        m_mode    = M_IDLE;
        m_pending = 1'b0;
        m_done    = 1'b0;
      end else begin
        bit    acc, hold, drq;
        item_t it;
        hold = bus.hold_req;
        drq  = bus.drain_req;
        acc  = bus.in_valid && exp_in_ready();
        for (int k = 0; k < mq.size(); k++) mq[k].pos = mv_np[k];
        if (mv_leave) void'(mq.pop_front());
        if (acc) begin
          it.d   = bus.in_data;
          it.pos = 0;
          mq.push_back(it);
        end
        m_done = 1'b0;
        case (m_mode)
          M_IDLE: begin
            if (hold) m_pending = m_pending | drq;
            else if (drq || m_pending) begin
              m_pending = 1'b0;
              if (acc) m_mode = M_DRAIN;
              else m_done = 1'b1;
            end else if (acc) m_mode = M_RUN;
          end
          M_RUN: begin
            if (hold) begin
              m_pending = m_pending | drq;
              m_mode    = M_HOLD;
            end else if (drq || m_pending) begin
              m_pending = 1'b0;
              m_mode    = M_DRAIN;
            end
          end
          M_HOLD: begin
            if (hold) m_pending = m_pending | drq;
            else if (drq || m_pending) begin
              m_pending = 1'b0;
              m_mode    = M_DRAIN;
            end else m_mode = M_RUN;
          end
          default: begin
            m_pending = 1'b0;
            if (!hold && mq.size() == 0) begin
              m_mode = M_IDLE;
              m_done = 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  initial begin
    forever begin
      bit e_ir, e_ov;
      @(negedge clk);
      e_ir = exp_in_ready();
      e_ov = exp_out_valid();
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, e_ir});
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, e_ov});
      if (e_ov) chk("out_data", {24'd0, bus.out_data}, {24'd0, mq[0].d});
      chk("drain_done", {31'd0, bus.drain_done}, {31'd0, m_done});
      chk("busy", {31'd0, bus.busy}, (m_mode != M_IDLE) ? 32'd1 : 32'd0);
      chk("occupancy", 32'(bus.occupancy), OCC_EN ? 32'(mq.size()) : 32'd0);
    end
  end

  // ---------------- stimulus
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit iv, input logic [7:0] d, input bit ordy,
                       input bit hold, input bit drq);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    bus.hold_req  = hold;
    bus.drain_req = drq;
  endtask

  initial begin
    int          dn, nemit, seen;
    logic [7:0]  got [$];

    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #2;
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_out_data", {24'd0, bus.out_data}, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_occupancy", 32'(bus.occupancy), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // T1: latency DEPTH-1 edges, back-to-back output
    drive(1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
    #1 chk("t1_first_in_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    bus.in_data = 8'h22;
    step();
    bus.in_data = 8'h33;
    step();
    bus.in_valid = 1'b0;
    #1 chk("t1_not_yet_valid", {31'd0, bus.out_valid}, 32'd0);
    step();
    #1 chk("t1_out_valid_n3", {31'd0, bus.out_valid}, 32'd1);
    chk("t1_data0", {24'd0, bus.out_data}, 32'h11);
    step();
    #1 chk("t1_data1", {24'd0, bus.out_data}, 32'h22);
    step();
    #1 chk("t1_data2", {24'd0, bus.out_data}, 32'h33);
    step();
    #1 chk("t1_empty", {31'd0, bus.out_valid}, 32'd0);

    // T2: backpressure fills the chain, release accepts the same cycle
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 8'hA0 + 8'(k), 1'b0, 1'b0, 1'b0);
      step();
    end
    bus.in_data = 8'hA4;
    #1 chk("t2_full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("t2_occupancy", 32'(bus.occupancy), OCC_EN ? 32'd4 : 32'd0);
    bus.out_ready = 1'b1;
    #1 chk("t2_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("t2_head", {24'd0, bus.out_data}, 32'hA0);
    step();
    bus.in_valid = 1'b0;
    for (int k = 1; k < 5; k++) begin
      #1 chk("t2_order", {24'd0, bus.out_data}, 32'hA0 + 32'(k));
      step();
    end

    // T3: hold freezes a full chain
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 8'hB0 + 8'(k), 1'b0, 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1 chk("t3_hold_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("t3_hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      step();
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #1 chk("t3_resume_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("t3_resume_data", {24'd0, bus.out_data}, 32'hB0 + 32'(k));
      step();
    end

    // T4: drain with two items in flight
    drive(1'b1, 8'hC0, 1'b0, 1'b0, 1'b0);
    step();
    bus.in_data = 8'hC1;
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    #1 chk("t4_drain_in_ready", {31'd0, bus.in_ready}, 32'd0);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    dn = 0;
    got.delete();
    for (int c = 0; c < 12; c++) begin
      #1;
      if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
      if (bus.drain_done) begin
        dn++;
        chk("t4_busy_at_done", {31'd0, bus.busy}, 32'd0);
      end
      step();
    end
    chk("t4_done_count", 32'(dn), 32'd1);
    chk("t4_emit_count", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      chk("t4_emit0", {24'd0, got[0]}, 32'hC0);
      chk("t4_emit1", {24'd0, got[1]}, 32'hC1);
    end
    chk("t4_busy_after", {31'd0, bus.busy}, 32'd0);

    // T5: hold and drain together -> hold first, drain after release
    drive(1'b1, 8'hD0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    step();
    bus.drain_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1 chk("t5_hold_busy", {31'd0, bus.busy}, 32'd1);
      chk("t5_hold_out_valid", {31'd0, bus.out_valid}, 32'd0);
      step();
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    dn = 0;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (bus.out_valid && bus.out_data == 8'hD0) seen++;
      if (bus.drain_done) dn++;
      step();
    end
    chk("t5_done_count", 32'(dn), 32'd1);
    chk("t5_item_emitted", 32'(seen), 32'd1);

    // T6: async reset with three items in flight
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 8'hE0 + 8'(k), 1'b0, 1'b0, 1'b0);
      step();
    end
    bus.in_valid = 1'b0;
    #1 rst = 1'b1;
    #1 chk("t6_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("t6_occupancy", 32'(bus.occupancy), 32'd0);
    chk("t6_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("t6_busy", {31'd0, bus.busy}, 32'd0);
    step();
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1 chk("t6_in_ready_after", {31'd0, bus.in_ready}, 32'd1);
    nemit = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (bus.out_valid) nemit++;
      step();
    end
    chk("t6_no_ghost_items", 32'(nemit), 32'd0);

    // Randomized traffic, checked by the compare process
    for (int c = 0; c < 1500; c++) begin
      drive($urandom_range(0, 9) < 7, 8'($urandom_range(0, 255)),
            $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
            $urandom_range(0, 39) == 0);
      step();
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    repeat (12) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
